// File: rtl/xoodyak_cmd_sequencer.sv
// Host command sequencer for the Xoodyak core: latches one command, drives the core until done, queues responses.
// Optional RUN watchdog enabled by defining XOODYAK_SEQ_TIMEOUT_EN.
//
// state | meaning
// IDLE  | core inputs zeroed, waiting for a command (needs a free response slot)
// RUN   | registered opmode/data driven to the core, waiting for core_finished
// GAP   | one cycle with core inputs zeroed so the core sees an idle opmode between commands
module xoodyak_cmd_sequencer #(
    parameter int DATA_W      = 352,
    parameter int TEXT_W      = 192,
    parameter int RSP_DEPTH   = 2,
    parameter int TIMEOUT_CYC = 63
) (
    input  logic              eph1,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [4:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [4:0]        core_opmode,
    output logic [DATA_W-1:0] core_data,
    input  logic [TEXT_W-1:0] core_textout,
    input  logic              core_finished,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [TEXT_W-1:0] rsp_text,
    output logic [2:0]        rsp_op,
    output logic              rsp_err,
    output logic              busy
);

    localparam int AW = $clog2(RSP_DEPTH);
    localparam int EW = TEXT_W + 4;

    if (RSP_DEPTH < 2 || (1 << AW) != RSP_DEPTH) begin : g_bad_depth
        $error("RSP_DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [4:0]          op_q;
    logic [DATA_W-1:0]   data_q;
    logic                start_ok;
    logic                accept, illegal, load, push, pop;
    logic [EW-1:0]       push_entry;
    logic [EW-1:0]       fifo_mem [RSP_DEPTH];
    logic [AW:0]         wr_ptr, rd_ptr;
    logic                empty, full;
    logic [EW-1:0]       head;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // start_ok keeps cmd_ready low during reset and until the first edge after release
    assign cmd_ready = start_ok && (state == IDLE) && !full;
    assign accept    = cmd_valid && cmd_ready;
    assign illegal   = (cmd_op[2:0] == 3'd0) || cmd_op[3];
    assign busy      = (state != IDLE);

    assign core_opmode = (state == RUN) ? op_q   : 5'd0;
    assign core_data   = (state == RUN) ? data_q : '0;

`ifdef XOODYAK_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;

    // Loaded so that terminal count is seen in the TIMEOUT_CYC-th RUN cycle
    always_ff @(posedge eph1 or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if (load) begin
            tmo_cnt <= TW'(TIMEOUT_CYC - 1);
        end else if (state == RUN && tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - TW'(1);
        end
    end
`endif

    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        push       = 1'b0;
        push_entry = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (illegal) begin
                        push       = 1'b1;
                        push_entry = {{TEXT_W{1'b0}}, cmd_op[2:0], 1'b1};
                    end else begin
                        load      = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (core_finished) begin
                    push       = 1'b1;
                    push_entry = {core_textout, op_q[2:0], 1'b0};
                    state_nxt  = GAP;
                end
`ifdef XOODYAK_SEQ_TIMEOUT_EN
                else if (tmo_cnt == '0) begin
                    push       = 1'b1;
                    push_entry = {{TEXT_W{1'b0}}, op_q[2:0], 1'b1};
                    state_nxt  = GAP;
                end
`endif
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge eph1 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            start_ok <= 1'b0;
            op_q     <= 5'd0;
            data_q   <= '0;
        end else begin
            state    <= state_nxt;
            start_ok <= 1'b1;
            if (load) begin
                op_q   <= cmd_op;
                data_q <= cmd_data;
            end
        end
    end

    // Response FIFO; a push never meets a full FIFO because acceptance required a free slot
    assign pop  = rsp_valid && rsp_ready;
    assign head = fifo_mem[rd_ptr[AW-1:0]];

    always_ff @(posedge eph1) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= push_entry;
        end
    end

    always_ff @(posedge eph1 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    assign rsp_valid = !empty;
    assign rsp_text  = rsp_valid ? head[EW-1:4] : '0;
    assign rsp_op    = rsp_valid ? head[3:1]    : 3'd0;
    assign rsp_err   = rsp_valid ? head[0]      : 1'b0;

endmodule

// File: tb/tb_xoodyak_cmd_sequencer.sv
// Directed self-checking bench for xoodyak_cmd_sequencer with hand-computed expectations.
// Timeout cases run only when XOODYAK_SEQ_TIMEOUT_EN is defined.
module tb_xoodyak_cmd_sequencer;

    localparam int DATA_W = 352;
    localparam int TEXT_W = 192;

    logic              eph1 = 1'b0;
    logic              reset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [4:0]        cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic [4:0]        core_opmode;
    logic [DATA_W-1:0] core_data;
    logic [TEXT_W-1:0] core_textout;
    logic              core_finished;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [TEXT_W-1:0] rsp_text;
    logic [2:0]        rsp_op;
    logic              rsp_err;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    localparam logic [DATA_W-1:0] D1 = {192'h4d4e4f5051525354555657584142434445464748494a4b4c, 160'h0};
    localparam logic [TEXT_W-1:0] T1 = 192'h87a01122334455667788_99aabbccddeeff0011223344_0e30;
    localparam logic [TEXT_W-1:0] T2 = 192'h0123456789abcdef_fedcba9876543210_a5a5a5a55a5a5a5a;
    localparam logic [TEXT_W-1:0] T3 = 192'hdeadbeef_00000000_cafef00d_11111111_22222222_33333333;
    localparam logic [DATA_W-1:0] D2 = {32'h13131313, 320'h0};

    xoodyak_cmd_sequencer dut (
        .eph1          (eph1),
        .reset_n       (reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_data      (cmd_data),
        .core_opmode   (core_opmode),
        .core_data     (core_data),
        .core_textout  (core_textout),
        .core_finished (core_finished),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_text      (rsp_text),
        .rsp_op        (rsp_op),
        .rsp_err       (rsp_err),
        .busy          (busy)
    );

    always #5 eph1 = ~eph1;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge eph1);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [DATA_W-1:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 5'd0;
        cmd_data  = '0;
    endtask

    task automatic pop_one();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 5'd0; cmd_data = '0;
        core_textout = '0; core_finished = 1'b0; rsp_ready = 1'b0;

        #3;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_opmode", core_opmode, 0);
        chk("rst_rsp_text", rsp_text, 0);
        tick(); tick();
        #2 reset_n = 1'b1;
        #1 chk("rel_ready_before_edge", cmd_ready, 0);
        tick();
        chk("rel_ready_after_edge", cmd_ready, 1);

        // crypt op, finished in RUN cycle 5
        issue(5'h04, D1);
        for (int i = 1; i <= 5; i++) begin
            chk($sformatf("crypt_opmode_c%0d", i), core_opmode, 5'h04);
            if (i == 5) begin
                core_finished = 1'b1;
                core_textout  = T1;
            end
            tick();
        end
        core_finished = 1'b0;
        core_textout  = '0;
        chk("crypt_data_gone", core_data, 0);
        chk("crypt_gap_opmode", core_opmode, 0);
        chk("crypt_gap_busy", busy, 1);
        chk("crypt_gap_ready", cmd_ready, 0);
        chk("crypt_rsp_valid", rsp_valid, 1);
        chk("crypt_rsp_text", rsp_text, T1);
        chk("crypt_rsp_op", rsp_op, 4);
        chk("crypt_rsp_err", rsp_err, 0);
        tick();
        chk("crypt_idle_busy", busy, 0);
        chk("crypt_idle_ready", cmd_ready, 1);
        pop_one();
        chk("crypt_popped", rsp_valid, 0);

        // core data presented during RUN
        issue(5'h04, D1);
        chk("crypt2_data", core_data, D1);
        core_finished = 1'b1; core_textout = T2;
        tick();
        core_finished = 1'b0;
        chk("crypt2_first_cycle_done", rsp_text, T2);
        tick(); pop_one();

        // idle op 0 is illegal
        issue(5'h00, D1);
        chk("op0_opmode", core_opmode, 0);
        chk("op0_busy", busy, 0);
        chk("op0_rsp_valid", rsp_valid, 1);
        chk("op0_rsp_err", rsp_err, 1);
        chk("op0_rsp_op", rsp_op, 0);
        chk("op0_rsp_text", rsp_text, 0);
        pop_one();

        // reserved bit3 is illegal
        issue(5'h0A, D1);
        chk("bit3_opmode", core_opmode, 0);
        chk("bit3_rsp_err", rsp_err, 1);
        chk("bit3_rsp_op", rsp_op, 2);
        pop_one();

        // core_finished outside RUN is ignored
        core_finished = 1'b1; core_textout = T3;
        tick(); tick();
        core_finished = 1'b0; core_textout = '0;
        chk("idle_fin_rsp_valid", rsp_valid, 0);
        chk("idle_fin_busy", busy, 0);

        // continue assoc op 0x13
        issue(5'h13, D2);
        chk("cont_opmode_c1", core_opmode, 5'h13);
        chk("cont_data", core_data, D2);
        tick();
        chk("cont_opmode_c2", core_opmode, 5'h13);
        core_finished = 1'b1; core_textout = T2;
        tick();
        core_finished = 1'b0;
        chk("cont_rsp_op", rsp_op, 3);
        chk("cont_rsp_err", rsp_err, 0);
        chk("cont_rsp_text", rsp_text, T2);
        tick(); pop_one();

        // FIFO fills with rsp_ready low
        issue(5'h00, '0);
        chk("fill_ready_one", cmd_ready, 1);
        issue(5'h07, D1);
        core_finished = 1'b1; core_textout = T3;
        tick();
        core_finished = 1'b0;
        tick();
        chk("fill_idle_busy", busy, 0);
        chk("fill_ready_full", cmd_ready, 0);
        chk("fill_head_err", rsp_err, 1);
        pop_one();
        chk("fill_ready_after_pop", cmd_ready, 1);
        chk("fill_head2_op", rsp_op, 7);
        chk("fill_head2_text", rsp_text, T3);

        // push of an illegal op coinciding with a pop
        cmd_valid = 1'b1; cmd_op = 5'h0D; rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0; cmd_op = 5'd0; rsp_ready = 1'b0;
        chk("pp_rsp_valid", rsp_valid, 1);
        chk("pp_rsp_op", rsp_op, 5);
        chk("pp_rsp_err", rsp_err, 1);
        chk("pp_ready", cmd_ready, 1);
        pop_one();
        chk("pp_empty", rsp_valid, 0);

        // reset in RUN cycle 3 with a response already queued
        issue(5'h00, '0);
        issue(5'h02, D1);
        tick(); tick();
        chk("rr_opmode_c3", core_opmode, 5'h02);
        #2 reset_n = 1'b0;
        #1;
        chk("rr_opmode_async", core_opmode, 0);
        chk("rr_data_async", core_data, 0);
        chk("rr_busy", busy, 0);
        chk("rr_rsp_valid", rsp_valid, 0);
        chk("rr_ready_low", cmd_ready, 0);
        tick();
        #2 reset_n = 1'b1;
        #1 chk("rr_ready_before_edge", cmd_ready, 0);
        tick();
        chk("rr_ready_after_edge", cmd_ready, 1);
        chk("rr_no_rsp", rsp_valid, 0);

`ifdef XOODYAK_SEQ_TIMEOUT_EN
        issue(5'h06, D1);
        for (int i = 1; i < 63; i++) tick();
        chk("tmo_c63_pending", rsp_valid, 0);
        chk("tmo_c63_opmode", core_opmode, 5'h06);
        tick();
        chk("tmo_rsp_valid", rsp_valid, 1);
        chk("tmo_rsp_err", rsp_err, 1);
        chk("tmo_rsp_op", rsp_op, 6);
        chk("tmo_rsp_text", rsp_text, 0);
        chk("tmo_gap_opmode", core_opmode, 0);
        tick(); pop_one();

        issue(5'h01, D1);
        for (int i = 1; i < 63; i++) tick();
        core_finished = 1'b1; core_textout = T1;
        tick();
        core_finished = 1'b0;
        chk("tmo_tie_err", rsp_err, 0);
        chk("tmo_tie_text", rsp_text, T1);
        chk("tmo_tie_op", rsp_op, 1);
        tick(); pop_one();
`else
        issue(5'h06, D1);
        for (int i = 0; i < 100; i++) tick();
        chk("notmo_still_busy", busy, 1);
        chk("notmo_no_rsp", rsp_valid, 0);
        core_finished = 1'b1; core_textout = T3;
        tick();
        core_finished = 1'b0;
        chk("notmo_rsp_err", rsp_err, 0);
        chk("notmo_rsp_text", rsp_text, T3);
        tick(); pop_one();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xoodyak_cmd_sequencer.md
XOODYAK_CMD_SEQUENCER -- requirements
Module: xoodyak_cmd_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 352, core input_data width.
REQ-002 SHALL have parameter TEXT_W, default 192, core textout width.
REQ-003 SHALL have parameter RSP_DEPTH, default 2, response FIFO entries (power of two, >=2).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 63, watchdog limit in cycles.
REQ-005 SHALL have one clock; reset is asynchronous and active-low.
REQ-006 SHALL have ports:
- eph1 in 1: clock, rising edge.
- reset_n in 1: asynchronous active-low reset.
- cmd_valid in 1: host command present.
- cmd_ready out 1: sequencer accepts a command.
- cmd_op in 5: bit4 continue, bits2:0 op (0 idle, 1 init, 2 nonce, 3 assoc, 4 crypt, 5 decrypt, 6 squeeze, 7 ratchet); bit3 reserved.
- cmd_data in DATA_W: operand, MSB-aligned.
- core_opmode out 5: opmode to xoodyak_build.
- core_data out DATA_W: input_data to xoodyak_build.
- core_textout in TEXT_W: core result.
- core_finished in 1: core operation complete.
- rsp_valid out 1: response at FIFO head.
- rsp_ready in 1: host takes response.
- rsp_text out TEXT_W: captured textout.
- rsp_op out 3: op of the completed command.
- rsp_err out 1: illegal op or timeout.
- busy out 1: state is not IDLE.

Function
REQ-007 SHALL implement FSM states IDLE, RUN, GAP.
REQ-008 SHALL drive cmd_ready = (state==IDLE) and response FIFO not full.
REQ-009 SHALL accept a command on an edge where cmd_valid and cmd_ready are both high, registering cmd_op and cmd_data.
REQ-010 SHALL, on accepting op 1..7, enter RUN and present the registered opmode and data on core_opmode/core_data from the following cycle, held constant throughout RUN.
REQ-011 SHALL, on accepting op 0 or a set bit3, leave the core untouched, push a response with rsp_err=1 and rsp_text=0, and remain in IDLE.
REQ-012 SHALL, in RUN, sample core_finished every edge, including the first RUN cycle; when it is high, push {core_textout, op, err=0} into the FIFO and enter GAP.
REQ-013 SHALL, in GAP, drive core_opmode=0 and core_data=0 for exactly one cycle, then return to IDLE.
REQ-014 SHALL drive core_opmode=0 and core_data=0 in IDLE.
REQ-015 SHALL present the FIFO head on rsp_* with rsp_valid high while non-empty; pop on rsp_valid and rsp_ready.
REQ-016 SHALL, on a simultaneous push and pop, keep the occupancy unchanged and preserve order.
REQ-017 SHALL keep the FIFO push path free of overflow, because cmd_ready already requires a free entry at acceptance.
REQ-018 SHALL give latency from accept edge to core_opmode valid = 1 cycle, and from the finished edge to rsp_valid = 1 cycle (FIFO empty case).
REQ-019 SHALL ignore core_finished outside RUN.

Reset
REQ-020 SHALL, on reset_n low, immediately set state=IDLE, empty the FIFO, and set core_opmode=0, core_data=0, rsp_valid=0, rsp_text=0, rsp_op=0, rsp_err=0, busy=0, cmd_ready=0.
REQ-021 SHALL, on reset asserted mid-RUN, abandon the command without a response; cmd_ready SHALL rise on the first edge after deassertion.

Configuration
REQ-022 SHALL, with XOODYAK_SEQ_TIMEOUT_EN defined, count RUN cycles; when the count reaches TIMEOUT_CYC without core_finished, it SHALL push {0, op, err=1} and enter GAP.
REQ-023 SHALL give core_finished priority when it coincides with timeout expiry, pushing err=0.
REQ-024 SHALL, without XOODYAK_SEQ_TIMEOUT_EN, omit the counter and wait in RUN indefinitely; rsp_err then flags only illegal ops.

Verification
REQ-025 SHALL cover: accept op 0x04, data 0x4d4e...4c<<160; core_finished after 5 cycles with textout 0x87a0...0e30 -> core_opmode=0x04 for 5 cycles, then 1 cycle at 0, rsp={0x87a0...0e30, 4, err=0}.
REQ-026 SHALL cover: cmd_op=0x00 -> no core_opmode change, rsp_err=1, rsp_op=0, rsp_text=0.
REQ-027 SHALL cover: rsp_ready held low and 2 ops issued -> cmd_ready=0 after the second response; one pop -> cmd_ready=1 the next cycle.
REQ-028 SHALL cover (with the macro): core_finished never asserted -> error response at RUN cycle 63; finished in cycle 63 -> err=0.
REQ-029 SHALL cover: reset_n pulsed low in RUN cycle 3 -> core_opmode=0 asynchronously, FIFO empty, no response.
REQ-030 SHALL cover: continue op 0x13 -> core_opmode=0x13 held; rsp_op=3.
